// File: rtl/decode_if.sv
// Valid/ready bundle between fetch, the decode stage and execute.
// master is the fetch/execute side; slave is the decode stage.
interface decode_if #(
   parameter int unsigned XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr_in;
   logic [XLEN-1:0] pc_in;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] pc_out;
   logic [4:0]      rd_out;
   logic [4:0]      rs1_out;
   logic [4:0]      rs2_out;
   logic [XLEN-1:0] imm_out;
   logic [22:0]     ctrl_out;

   modport master (
      output flush, in_valid, instr_in, pc_in, out_ready,
      input  in_ready, out_valid, pc_out, rd_out, rs1_out, rs2_out, imm_out, ctrl_out
   );

   modport slave (
      input  flush, in_valid, instr_in, pc_in, out_ready,
      output in_ready, out_valid, pc_out, rd_out, rs1_out, rs2_out, imm_out, ctrl_out
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with a DEPTH-entry output FIFO between fetch and execute.
// Define DECODE_RV32M_EN to also decode the M-extension (MUL..REMU).
module decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input logic     clk,
   input logic     rst,
   decode_if.slave bus
);
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned CTRLW = 23;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] BR_ZERO   = 4'b0101;
   localparam logic [3:0] BR_NZERO  = 4'b1010;
   localparam logic [3:0] BR_ALWAYS = 4'b1111;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [XLEN-1:0]  imm;
      logic [CTRLW-1:0] ctrl;
   } entry_t;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign instr  = bus.instr_in;
   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   logic        r1, r2, wr, mr, mw, zx, bsrc, ill, md, alt, s1pc, s1z, s2imm, s2four;
   logic [1:0]  width;
   logic [3:0]  bop;
   logic [2:0]  fn;
   logic [31:0] imm32;

   // Instruction decode; illegal encodings collapse to a bare illegal flag.
   always_comb begin
      r1 = 1'b0; r2 = 1'b0; wr = 1'b0; mr = 1'b0; mw = 1'b0; zx = 1'b0;
      bsrc = 1'b0; ill = 1'b0; md = 1'b0; alt = 1'b0;
      s1pc = 1'b0; s1z = 1'b0; s2imm = 1'b0; s2four = 1'b0;
      width = 2'b00; bop = 4'b0000; fn = 3'b000; imm32 = 32'd0;
      case (opcode)
         OPC_LUI:   begin wr = 1'b1; s1z = 1'b1; s2imm = 1'b1; imm32 = imm_u; end
         OPC_AUIPC: begin wr = 1'b1; s1pc = 1'b1; s2imm = 1'b1; imm32 = imm_u; end
         OPC_JAL: begin
            wr = 1'b1; s1pc = 1'b1; s2four = 1'b1; bop = BR_ALWAYS; imm32 = imm_j;
         end
         OPC_JALR: begin
            r1 = 1'b1; wr = 1'b1; s1pc = 1'b1; s2four = 1'b1;
            bop = BR_ALWAYS; bsrc = 1'b1; imm32 = imm_i;
            ill = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            r1 = 1'b1; r2 = 1'b1; fn = f3; imm32 = imm_b;
            case (f3)
               3'b000, 3'b101, 3'b111: bop = BR_ZERO;
               3'b001, 3'b100, 3'b110: bop = BR_NZERO;
               default:                ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            r1 = 1'b1; wr = 1'b1; mr = 1'b1; s2imm = 1'b1; imm32 = imm_i; zx = f3[2];
            case (f3)
               3'b000, 3'b100: width = 2'b10;
               3'b001, 3'b101: width = 2'b01;
               3'b010:         width = 2'b00;
               default:        ill = 1'b1;
            endcase
         end
         OPC_STORE: begin
            r1 = 1'b1; r2 = 1'b1; mw = 1'b1; s2imm = 1'b1; imm32 = imm_s;
            case (f3)
               3'b000:  width = 2'b10;
               3'b001:  width = 2'b01;
               3'b010:  width = 2'b00;
               default: ill = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            r1 = 1'b1; wr = 1'b1; s2imm = 1'b1; fn = f3; imm32 = imm_i;
            if (f3 == 3'b001) ill = (f7 != 7'b0000000);
            else if (f3 == 3'b101) begin
               alt = instr[30];
               ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
         end
         OPC_OP: begin
            r1 = 1'b1; r2 = 1'b1; wr = 1'b1; fn = f3;
            if (f7 == 7'b0000000) alt = 1'b0;
            else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) alt = 1'b1;
`ifdef DECODE_RV32M_EN
            else if (f7 == 7'b0000001) md = 1'b1;
`endif
            else ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         r1 = 1'b0; r2 = 1'b0; wr = 1'b0; mr = 1'b0; mw = 1'b0; zx = 1'b0;
         bsrc = 1'b0; md = 1'b0; alt = 1'b0;
         s1pc = 1'b0; s1z = 1'b0; s2imm = 1'b0; s2four = 1'b0;
         width = 2'b00; bop = 4'b0000; fn = 3'b000; imm32 = 32'd0;
      end
      wr = wr && (instr[11:7] != 5'd0);
   end

   // Unused register fields read 0 so execute never sees stray immediate bits.
   entry_t dec;
   assign dec.pc   = bus.pc_in;
   assign dec.rd   = wr ? instr[11:7]  : 5'd0;
   assign dec.rs1  = r1 ? instr[19:15] : 5'd0;
   assign dec.rs2  = r2 ? instr[24:20] : 5'd0;
   assign dec.imm  = XLEN'($signed(imm32));
   assign dec.ctrl = {s2four, s2imm, s1z, s1pc, alt, fn, md, ill, bsrc, bop, zx, width, mw, mr, wr, r2, r1};

   entry_t         mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           push, pop;

   assign bus.in_ready  = (count < CW'(DEPTH));
   assign bus.out_valid = (count != CW'(0));
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // FIFO bookkeeping; flush wins over push and pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (bus.flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
         if (pop)  rd_ptr <= PW'(rd_ptr + PW'(1));
         case ({push, pop})
            2'b10:   count <= CW'(count + CW'(1));
            2'b01:   count <= CW'(count - CW'(1));
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !bus.flush) mem[wr_ptr] <= dec;
   end

   entry_t head;
   assign head        = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.pc_out  = head.pc;
   assign bus.rd_out  = head.rd;
   assign bus.rs1_out = head.rs1;
   assign bus.rs2_out = head.rs2;
   assign bus.imm_out = head.imm;
   assign bus.ctrl_out = head.ctrl;
endmodule
